udp_multi_transmit_handler: RTL

Multi-channel successor to the single-stream UDP transmit front end. It accepts NUM_CHANNELS 9-bit framed byte streams, where bit 8 marks the first byte of a frame. A round-robin arbiter grants one channel at a time. The block parses a 16-byte header (MAC dst, IPv4 dst, UDP dst, UDP src, UDP data size), validates the size, then streams the payload to the UDP/IPv4/Ethernet transmitter. Malformed frames raise error pulses.

---
 rtl/udp_transmit_pkg.sv | 28 ++
 rtl/udp_multi_transmit_handler_if.sv | 38 +++
 rtl/cycle_timer.sv | 20 ++
 rtl/round_robin_arbiter.sv | 29 ++
 rtl/udp_multi_transmit_handler.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/udp_transmit_pkg.sv
// Shared types and header layout for the multi-channel UDP transmit front end.
package udp_transmit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_HEADER,
        S_CHECK_SIZE,
        S_DRAIN,
        S_ENABLE_TRANSMIT,
        S_PUSH_UDP_DATA
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RESTART  = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_BAD_SIZE = 2'd3
    } err_code_t;

    localparam int HEADER_BYTES = 16;
    // Byte offsets of each field inside the big-endian header
    localparam int MAC_OFS      = 0;
    localparam int IPV4_OFS     = 6;
    localparam int UDP_DST_OFS  = 10;
    localparam int UDP_SRC_OFS  = 12;
    localparam int SIZE_OFS     = 14;

endpackage

// File: rtl/udp_multi_transmit_handler_if.sv
// Upstream byte streams plus transmitter-side handshake and parsed header outputs.
interface udp_multi_transmit_handler_if #(
    parameter int NUM_CHANNELS = 4
);
    localparam int CW = $clog2(NUM_CHANNELS);

    logic [9*NUM_CHANNELS-1:0] data;
    logic [NUM_CHANNELS-1:0]   data_enable;
    logic [NUM_CHANNELS-1:0]   data_ready;
    logic                      enable;
    logic                      udp_data_enable;
    logic [47:0]               mac_destination;
    logic [31:0]               ipv4_destination;
    logic [15:0]               udp_destination;
    logic [15:0]               udp_source;
    logic [15:0]               udp_data_size;
    logic [7:0]                udp_data;
    logic                      udp_data_valid;
    logic                      transmit_valid;
    logic [CW-1:0]             active_channel;
    logic                      ready;
    logic                      error;
    logic [1:0]                error_code;

    modport slave (
        input  data, data_enable, enable, udp_data_enable,
        output data_ready, mac_destination, ipv4_destination, udp_destination,
               udp_source, udp_data_size, udp_data, udp_data_valid,
               transmit_valid, active_channel, ready, error, error_code
    );

    modport master (
        output data, data_enable, enable, udp_data_enable,
        input  data_ready, mac_destination, ipv4_destination, udp_destination,
               udp_source, udp_data_size, udp_data, udp_data_valid,
               transmit_valid, active_channel, ready, error, error_code
    );
endinterface

// File: rtl/cycle_timer.sv
// Down-counting idle timer: reload on activity, expired once the count reaches zero.
module cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n)             count <= '0;
        else if (load)            count <= limit;
        else if (count != '0)     count <= count - 1'b1;
    end

    assign expired = (count == '0);
endmodule

// File: rtl/round_robin_arbiter.sv
// Picks the first requester at or after the pointer, wrapping around.
module round_robin_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int CW           = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] request,
    input  logic [CW-1:0]           pointer,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic [CW-1:0]           grant_index,
    output logic                    grant_valid
);
    int idx;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(pointer) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!grant_valid && request[CW'(idx)]) begin
                grant_valid        = 1'b1;
                grant[CW'(idx)]    = 1'b1;
                grant_index        = CW'(idx);
            end
        end
    end
endmodule

// File: rtl/udp_multi_transmit_handler.sv
// Arbitrates framed byte channels, parses the 16-byte UDP header and streams
// the payload to the transmitter, flagging restarts, timeouts and bad sizes.
module udp_multi_transmit_handler
    import udp_transmit_pkg::*;
#(
    parameter int          NUM_CHANNELS      = 4,
    parameter logic [15:0] TIMEOUT_LIMIT     = 16'h00FF,
    parameter int          MAX_UDP_DATA_SIZE = 1472
) (
    input  logic                          clock,
    input  logic                          reset_n,
    udp_multi_transmit_handler_if.slave   bus
);
    localparam int CW = $clog2(NUM_CHANNELS);

    state_t                        state, next_state;
    logic [NUM_CHANNELS-1:0][8:0]  ch_data;
    logic [NUM_CHANNELS-1:0]       sof_vec, request, grant, active_onehot, data_ready;
    logic [CW-1:0]                 grant_index, active_channel, pointer;
    logic                          grant_valid;
    logic [8*HEADER_BYTES-1:0]     hdr;
    logic [3:0]                    byte_cnt, hdr_idx;
    logic [15:0]                   remaining, size_w;
    logic                          sof_act, en_act;
    logic [7:0]                    byte_act;
    logic                          hdr_we, pay_we, tx_start, handshake, xfer;
    logic                          err_pulse, timer_load, expired;
    err_code_t                     err_code_d;
    logic [7:0]                    udp_data_r;
    logic                          udp_data_valid_r, transmit_valid_r, ready_r, error_r;
    logic [1:0]                    error_code_r;

    assign ch_data  = bus.data;
    assign sof_act  = ch_data[active_channel][8];
    assign byte_act = ch_data[active_channel][7:0];
    assign en_act   = bus.data_enable[active_channel];
    assign size_w   = hdr[8*(HEADER_BYTES-SIZE_OFS)-1 -: 16];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_sof
        assign sof_vec[i] = ch_data[i][8];
    end
    assign request = bus.data_enable & sof_vec;

    round_robin_arbiter #(.NUM_CHANNELS(NUM_CHANNELS), .CW(CW)) u_arb (
        .request     (request),
        .pointer     (pointer),
        .grant       (grant),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    cycle_timer #(.WIDTH(16)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .limit   (TIMEOUT_LIMIT),
        .expired (expired)
    );

    always_comb begin
        next_state = state;
        data_ready = '0;
        hdr_we     = 1'b0;
        hdr_idx    = byte_cnt;
        pay_we     = 1'b0;
        tx_start   = 1'b0;
        handshake  = 1'b0;
        err_pulse  = 1'b0;
        err_code_d = ERR_NONE;
        case (state)
            S_IDLE: begin
                // Stray mid-frame bytes are swallowed; start bytes wait for a grant
                data_ready = bus.data_enable & ~sof_vec;
                if (grant_valid) next_state = S_GET_HEADER;
            end
            S_GET_HEADER: begin
                data_ready = active_onehot;
                if (en_act) begin
                    hdr_we = 1'b1;
                    if (sof_act && byte_cnt != 4'd0) begin
                        hdr_idx    = 4'd0;
                        err_pulse  = 1'b1;
                        err_code_d = ERR_RESTART;
                    end else if (byte_cnt == 4'(HEADER_BYTES-1)) begin
                        next_state = S_CHECK_SIZE;
                    end
                end
            end
            S_CHECK_SIZE: begin
                if (size_w == 16'd0 || size_w > 16'(MAX_UDP_DATA_SIZE)) begin
                    err_pulse  = 1'b1;
                    err_code_d = ERR_BAD_SIZE;
                    next_state = S_DRAIN;
                end else begin
                    next_state = S_ENABLE_TRANSMIT;
                end
            end
            S_DRAIN: begin
                data_ready = active_onehot & {NUM_CHANNELS{~sof_act}};
                if (en_act && sof_act) next_state = S_IDLE;
            end
            S_ENABLE_TRANSMIT: begin
                if (bus.enable) begin
                    handshake  = 1'b1;
                    tx_start   = 1'b1;
                    next_state = S_PUSH_UDP_DATA;
                end
            end
            S_PUSH_UDP_DATA: begin
                if (en_act && sof_act) begin
                    // Truncated frame: leave the start byte for the next arbitration
                    err_pulse  = 1'b1;
                    err_code_d = ERR_RESTART;
                    next_state = S_IDLE;
                end else begin
                    data_ready = active_onehot & {NUM_CHANNELS{bus.udp_data_enable}};
                    if (en_act && bus.udp_data_enable) begin
                        pay_we = 1'b1;
                        if (remaining == 16'd1) next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase

        xfer       = |(data_ready & bus.data_enable);
        timer_load = (state == S_IDLE) || xfer || handshake || (next_state != state);
        // Progress in the expiry cycle wins over the timeout
        if (state != S_IDLE && expired && !timer_load) begin
            next_state = S_IDLE;
            err_pulse  = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            pointer          <= '0;
            active_channel   <= '0;
            active_onehot    <= '0;
            byte_cnt         <= '0;
            hdr              <= '0;
            remaining        <= '0;
            udp_data_r       <= '0;
            udp_data_valid_r <= 1'b0;
            transmit_valid_r <= 1'b0;
            ready_r          <= 1'b0;
            error_r          <= 1'b0;
            error_code_r     <= '0;
        end else begin
            state            <= next_state;
            ready_r          <= (next_state == S_IDLE);
            error_r          <= err_pulse;
            transmit_valid_r <= tx_start;
            udp_data_valid_r <= pay_we;
            if (err_pulse) error_code_r <= err_code_d;
            if (state == S_IDLE && grant_valid) begin
                active_channel <= grant_index;
                active_onehot  <= grant;
                byte_cnt       <= '0;
            end
            if (hdr_we) begin
                for (int b = 0; b < HEADER_BYTES; b++)
                    if (hdr_idx == 4'(b)) hdr[8*(HEADER_BYTES-1-b) +: 8] <= byte_act;
                byte_cnt <= hdr_idx + 4'd1;
            end
            if (tx_start) remaining <= size_w;
            if (pay_we) begin
                udp_data_r <= byte_act;
                remaining  <= remaining - 16'd1;
            end
            if (state != S_IDLE && next_state == S_IDLE)
                pointer <= (active_channel == CW'(NUM_CHANNELS-1)) ? '0 : active_channel + 1'b1;
        end
    end

    assign bus.data_ready       = data_ready;
    assign bus.mac_destination  = hdr[8*(HEADER_BYTES-MAC_OFS)-1     -: 48];
    assign bus.ipv4_destination = hdr[8*(HEADER_BYTES-IPV4_OFS)-1    -: 32];
    assign bus.udp_destination  = hdr[8*(HEADER_BYTES-UDP_DST_OFS)-1 -: 16];
    assign bus.udp_source       = hdr[8*(HEADER_BYTES-UDP_SRC_OFS)-1 -: 16];
    assign bus.udp_data_size    = size_w;
    assign bus.udp_data         = udp_data_r;
    assign bus.udp_data_valid   = udp_data_valid_r;
    assign bus.transmit_valid   = transmit_valid_r;
    assign bus.active_channel   = active_channel;
    assign bus.ready            = ready_r;
    assign bus.error            = error_r;
    assign bus.error_code       = error_code_r;
endmodule
